alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 148 ++++++++++++++
 tb/tb_alu_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: register-file sequencer that feeds an external combinational ALU.
// Each accepted instruction takes two edges: operand fetch, then commit of result and flags.
// Optional build macro: ALU_SEQ_ILLEGAL_EN -- when defined, op 7 is rejected (err pulse, no write).

package alu_types;
  typedef enum logic [2:0] {
    CMD_ADD = 3'd0,
    CMD_SUB = 3'd1,
    CMD_INC = 3'd2,
    CMD_DEC = 3'd3,
    CMD_AND = 3'd4,
    CMD_OR  = 3'd5,
    CMD_NOT = 3'd6,
    CMD_ILL = 3'd7
  } cmd_t;
endpackage

module alu_seq #(
  parameter int unsigned NREGS = 4,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [2:0]    instr_op,
  input  logic [AW-1:0] instr_rd,
  input  logic [AW-1:0] instr_ra,
  input  logic [AW-1:0] instr_rb,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [AW-1:0] rd_sel,
  output logic [31:0]   rd_data,
  output logic [2:0]    alu_cmd,
  output logic [31:0]   alu_a,
  output logic [31:0]   alu_b,
  input  logic [31:0]   alu_data,
  input  logic          alu_v,
  input  logic          alu_c,
  input  logic          alu_n,
  input  logic          alu_z,
  output logic [3:0]    flags,
  output logic          done,
  output logic          err
);

  localparam int unsigned DW = 32;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EXEC = 1'b1;

  logic [0:0]    state_q,   state_d;
  logic [DW-1:0] regs_q [NREGS];
  logic [DW-1:0] regs_d [NREGS];
  logic [2:0]    alu_cmd_q, alu_cmd_d;
  logic [DW-1:0] alu_a_q,   alu_a_d;
  logic [DW-1:0] alu_b_q,   alu_b_d;
  logic [AW-1:0] rd_q,      rd_d;
  logic [3:0]    flags_q,   flags_d;
  logic          done_q,    done_d;
  logic          err_q,     err_d;
  logic          illegal_c;

  // Rejection of op 7 exists only in the illegal-enabled build
  always_comb begin
`ifdef ALU_SEQ_ILLEGAL_EN
    illegal_c = (alu_cmd_q == 3'(alu_types::CMD_ILL));
`else
    illegal_c = 1'b0;
`endif
  end

  // Next-state: host write first, so a same-edge ALU commit to the same register overrides it
  always_comb begin
    state_d   = state_q;
    regs_d    = regs_q;
    alu_cmd_d = alu_cmd_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    rd_d      = rd_q;
    flags_d   = flags_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    if (wr_en) begin
      regs_d[wr_addr] = wr_data;
    end

    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          alu_cmd_d = instr_op;
          alu_a_d   = regs_q[instr_ra];
          alu_b_d   = regs_q[instr_rb];
          rd_d      = instr_rd;
          state_d   = S_EXEC;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (illegal_c) begin
          err_d = 1'b1;
        end else begin
          regs_d[rd_q] = alu_data;
          flags_d      = {alu_v, alu_c, alu_n, alu_z};
          done_d       = 1'b1;
        end
      end
    endcase
  end

  // State and datapath registers; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
      alu_cmd_q <= 3'(alu_types::CMD_ADD);
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      rd_q      <= '0;
      flags_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      regs_q    <= regs_d;
      alu_cmd_q <= alu_cmd_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      rd_q      <= rd_d;
      flags_q   <= flags_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign instr_ready = (state_q == S_IDLE);
  assign rd_data     = regs_q[rd_sel];
  assign alu_cmd     = alu_cmd_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign flags       = flags_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed bench for alu_seq with a behavioural external ALU.
// Honours ALU_SEQ_ILLEGAL_EN the same way as the design for the op 7 case.

module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  instr_op;
  logic [1:0]  instr_rd, instr_ra, instr_rb;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  rd_sel;
  logic [31:0] rd_data;
  logic [2:0]  alu_cmd;
  logic [31:0] alu_a, alu_b;
  logic [31:0] alu_data;
  logic        alu_v, alu_c, alu_n, alu_z;
  logic [3:0]  flags;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_seq dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_ra(instr_ra), .instr_rb(instr_rb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_sel(rd_sel), .rd_data(rd_data),
    .alu_cmd(alu_cmd), .alu_a(alu_a), .alu_b(alu_b),
    .alu_data(alu_data), .alu_v(alu_v), .alu_c(alu_c), .alu_n(alu_n), .alu_z(alu_z),
    .flags(flags), .done(done), .err(err)
  );

  // External ALU model; carry is meaningful only for ADD/SUB
  always_comb begin
    logic [32:0] s;
    s        = '0;
    alu_data = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    case (alu_cmd)
      3'd0: begin
        s = {1'b0, alu_a} + {1'b0, alu_b};
        alu_data = s[31:0];
        alu_c    = s[32];
        alu_v    = (alu_a[31] == alu_b[31]) && (alu_data[31] != alu_a[31]);
      end
      3'd1: begin
        alu_data = alu_a - alu_b;
        alu_c    = alu_a < alu_b;
        alu_v    = (alu_a[31] != alu_b[31]) && (alu_data[31] != alu_a[31]);
      end
      3'd2: begin
        alu_data = alu_a + 32'd1;
        alu_v    = (alu_a == 32'h7FFF_FFFF);
      end
      3'd3: begin
        alu_data = alu_a - 32'd1;
        alu_v    = (alu_a == 32'h8000_0000);
      end
      3'd4: alu_data = alu_a & alu_b;
      3'd5: alu_data = alu_a | alu_b;
      3'd6: alu_data = ~alu_a;
      default: alu_data = '0;
    endcase
    alu_n = alu_data[31];
    alu_z = (alu_data == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_is(input logic [1:0] r, input logic [31:0] exp, input string tag);
    rd_sel = r;
    #1;
    check(tag, rd_data, exp);
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] ra,
                       input logic [1:0] rb);
    instr_valid = 1'b1;
    instr_op    = op;
    instr_rd    = rd;
    instr_ra    = ra;
    instr_rb    = rb;
  endtask

  task automatic host_wr(input logic [1:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr_op = '0; instr_rd = '0; instr_ra = '0;
    instr_rb = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_sel = '0;
    repeat (3) step();
    check("rst_ready_low", 32'(instr_ready), 32'd1);
    rst_n = 1'b1;
    step();

    // Reset state
    for (int i = 0; i < 4; i++) reg_is(2'(i), 32'd0, $sformatf("rst_r%0d", i));
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_cmd", 32'(alu_cmd), 32'd0);

    // ADD r3 = r1 + r2
    host_wr(2'd1, 32'd5);
    host_wr(2'd2, 32'd3);
    reg_is(2'd1, 32'd5, "wr_r1");
    issue(3'd0, 2'd3, 2'd1, 2'd2);
    step();
    instr_valid = 1'b0;
    check("add_cmd", 32'(alu_cmd), 32'd0);
    check("add_a", alu_a, 32'd5);
    check("add_b", alu_b, 32'd3);
    check("add_ready_exec", 32'(instr_ready), 32'd0);
    check("add_no_early_done", 32'(done), 32'd0);
    step();
    check("add_done", 32'(done), 32'd1);
    check("add_flags", 32'(flags), 32'h0);
    reg_is(2'd3, 32'd8, "add_r3");
    step();
    check("add_done_1cyc", 32'(done), 32'd0);

    // SUB r0 = r2 - r1 with instr_valid held high through EXEC
    issue(3'd1, 2'd0, 2'd2, 2'd1);
    step();
    issue(3'd5, 2'd3, 2'd3, 2'd3);
    check("sub_cmd", 32'(alu_cmd), 32'd1);
    step();
    instr_valid = 1'b0;
    check("sub_done", 32'(done), 32'd1);
    check("sub_flags", 32'(flags), 32'b0110);
    check("sub_held_ignored", 32'(alu_cmd), 32'd1);
    reg_is(2'd0, 32'hFFFF_FFFE, "sub_r0");
    reg_is(2'd3, 32'd8, "sub_r3_kept");
    step();

    // Op 7: rejected when the feature is built in, otherwise commits zero
    issue(3'd7, 2'd2, 2'd2, 2'd2);
    step();
    instr_valid = 1'b0;
    step();
`ifdef ALU_SEQ_ILLEGAL_EN
    check("ill_err", 32'(err), 32'd1);
    check("ill_done", 32'(done), 32'd0);
    check("ill_flags", 32'(flags), 32'b0110);
    reg_is(2'd2, 32'd3, "ill_r2");
`else
    check("ill_err", 32'(err), 32'd0);
    check("ill_done", 32'(done), 32'd1);
    check("ill_flags", 32'(flags), 32'b0001);
    reg_is(2'd2, 32'd0, "ill_r2");
`endif
    step();
    check("ill_err_1cyc", 32'(err), 32'd0);

    // INC r1 = r2 + 1 wraps to 0; host write to r1 on the commit edge is dropped
    host_wr(2'd2, 32'hFFFF_FFFF);
    issue(3'd2, 2'd1, 2'd2, 2'd2);
    step();
    instr_valid = 1'b0;
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 32'h1234;
    step();
    wr_en = 1'b0;
    check("inc_done", 32'(done), 32'd1);
    check("inc_flags", 32'(flags), 32'b0001);
    reg_is(2'd1, 32'd0, "inc_r1_alu_wins");
    step();

    // DEC r3 with a host write to another register on the commit edge
    issue(3'd3, 2'd3, 2'd3, 2'd0);
    step();
    instr_valid = 1'b0;
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 32'hAA;
    step();
    wr_en = 1'b0;
    reg_is(2'd3, 32'd7, "dec_r3");
    reg_is(2'd2, 32'hAA, "dec_host_r2");
    step();

    // NOT r2 = ~r0 and AND r1 = r3 & r2
    issue(3'd6, 2'd2, 2'd0, 2'd0);
    step(); instr_valid = 1'b0; step();
    reg_is(2'd2, 32'd1, "not_r2");
    step();
    issue(3'd4, 2'd1, 2'd3, 2'd2);
    step(); instr_valid = 1'b0; step();
    reg_is(2'd1, 32'd1, "and_r1");
    check("and_flags", 32'(flags), 32'b0000);
    step();

    // Reset mid-EXEC aborts: OR into r0 never commits
    issue(3'd5, 2'd0, 2'd3, 2'd2);
    step();
    instr_valid = 1'b0;
    check("abort_in_exec", 32'(instr_ready), 32'd0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    check("abort_done", 32'(done), 32'd0);
    check("abort_ready", 32'(instr_ready), 32'd1);
    check("abort_flags", 32'(flags), 32'd0);
    reg_is(2'd0, 32'd0, "abort_r0");
    step();
    check("abort_done_late", 32'(done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
